cpu_ram2021: RTL and testbench
==============================

CPU_RAM2021 -- requirements
Module: cpu_ram2021

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the word-address width (depth is 2^ADDR_W words).
REQ-002 The block SHALL have parameter PROT_TOP, default 16, meaning the first writable address when write protection is compiled in.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port wrEn, input, 1 bit: CPU write enable.
REQ-006 The block SHALL have port addr_toRAM, input, ADDR_W bits: CPU word address.
REQ-007 The block SHALL have port data_toRAM, input, 16 bits: CPU write data.
REQ-008 The block SHALL have port data_fromRAM, output, 16 bits: registered read data to the CPU.
REQ-009 The block SHALL have port load_valid, input, 1 bit: loader beat valid.
REQ-010 The block SHALL have port load_ready, output, 1 bit: loader beat accepted when high with load_valid.
REQ-011 The block SHALL have port load_data, input, 16 bits: loader word.
REQ-012 The block SHALL have port load_last, input, 1 bit: marks the final loader beat.
REQ-013 The block SHALL have port cpu_rst, output, 1 bit: active-high reset driven to the CPU.
REQ-014 The block SHALL have port loaded, output, 1 bit: high once the program load has completed.
REQ-015 The block SHALL have port prot_viol, output, 1 bit: sticky protected-write flag.

Function
REQ-016 The block SHALL implement a two-state FSM, LOAD then RUN.
REQ-017 LOAD: load_ready=1 and cpu_rst=1; each accepted beat writes load_data to mem[ptr], then ptr increments.
REQ-018 LOAD: an accepted beat with load_last=1, or at ptr=2^ADDR_W-1, SHALL move the FSM to RUN on the same edge; ptr never wraps.
REQ-019 LOAD: wrEn, addr_toRAM and data_toRAM SHALL be ignored, and data_fromRAM SHALL hold 0.
REQ-020 RUN: load_ready=0, cpu_rst=0 and loaded=1; load_valid is ignored; the FSM stays in RUN until reset.
REQ-021 RUN read: data_fromRAM SHALL equal mem[addr_toRAM] as sampled on the previous edge, giving exactly one cycle of latency, and is updated every cycle.
REQ-022 RUN write: with wrEn=1, mem[addr_toRAM] SHALL take data_toRAM at the edge.
REQ-023 A read and a write to the same address on the same edge SHALL return the old (read-first) data.
REQ-024 cpu_rst SHALL be registered, so the CPU leaves reset on the first cycle in RUN, with no glitch.

Reset
REQ-025 On rst low, asynchronously: state=LOAD, ptr=0, data_fromRAM=0, cpu_rst=1, load_ready=1, loaded=0, prot_viol=0.
REQ-026 The memory array SHALL NOT be cleared by reset, and reset in mid-RUN or mid-LOAD SHALL preserve its contents.
REQ-027 A reset asserted in mid-LOAD SHALL restart the load at address 0.

Configuration
REQ-028 With macro CPU_RAM2021_WRPROT_EN defined, RUN writes with addr_toRAM < PROT_TOP SHALL be dropped and set prot_viol; the loader is never protected.
REQ-029 Without CPU_RAM2021_WRPROT_EN, all RUN writes SHALL be performed and prot_viol SHALL be tied 0.

Structure
REQ-030 Shared package cpu2021_pkg SHALL hold ADDR_W, DATA_W=16, the LOAD/RUN state enum and the CPU opcode constants.
REQ-031 Sub-module cpu_ram2021_array SHALL be a single-port synchronous read-first RAM; the FSM, loader and protection logic SHALL live in the top.

Verification
REQ-032 Load 3 beats 0x1111, 0x2222, 0x3333 (last on beat 3) -> loaded=1 and cpu_rst=0 on the next cycle; addr 1 read gives 0x2222 one cycle later.
REQ-033 load_valid toggled 1,0,1 with last on beat 2 -> exactly 2 words written, at ptr 0 and 1.
REQ-034 RUN write 0xBEEF to addr 0x0100 while reading the same address -> old value returned that cycle and 0xBEEF on the next read.
REQ-035 With macro defined, write 0x00FF to addr 5 -> mem[5] unchanged and prot_viol=1 until rst; without the macro -> mem[5]=0x00FF and prot_viol=0.
REQ-036 rst pulsed low in RUN -> cpu_rst=1, load_ready=1 and data_fromRAM=0 immediately; previously loaded words remain readable after a 1-beat reload.

Source files
------------

// File: rtl/cpu2021_pkg.sv
// Shared constants for the 2021 CPU: memory geometry, RAM loader states and opcodes.
package cpu2021_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Opcode field occupies the top nibble of each instruction word.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;
endpackage

// File: rtl/cpu_ram2021_array.sv
// Single-port synchronous RAM, read-first; the read register clears asynchronously
// on rst and synchronously on clr, while the array contents are never reset.
module cpu_ram2021_array #(
    parameter int ADDR_W = cpu2021_pkg::ADDR_W,
    parameter int DATA_W = cpu2021_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Both blocks sample mem on the same edge, so a colliding write returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     rdata <= '0;
        else if (clr) rdata <= '0;
        else          rdata <= mem[addr];
    end
endmodule

// File: rtl/cpu_ram2021.sv
// Program RAM with a boot loader: LOAD streams words in while holding the CPU in reset,
// then RUN serves the CPU. Optional write protection below PROT_TOP: CPU_RAM2021_WRPROT_EN.
module cpu_ram2021 #(
    parameter int ADDR_W   = cpu2021_pkg::ADDR_W,
    parameter int PROT_TOP = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wrEn,
    input  logic [ADDR_W-1:0]              addr_toRAM,
    input  logic [cpu2021_pkg::DATA_W-1:0] data_toRAM,
    output logic [cpu2021_pkg::DATA_W-1:0] data_fromRAM,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [cpu2021_pkg::DATA_W-1:0] load_data,
    input  logic                           load_last,
    output logic                           cpu_rst,
    output logic                           loaded,
    output logic                           prot_viol
);
    import cpu2021_pkg::*;

`ifdef CPU_RAM2021_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              in_run;
    logic              beat;
    logic              prot_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    assign in_run   = (state == RUN);
    assign beat     = !in_run && load_valid;
    assign prot_hit = PROT_EN && (32'(addr_toRAM) < PROT_TOP);

    // The single RAM port belongs to the loader in LOAD and to the CPU in RUN.
    always_comb begin
        ram_addr  = ptr;
        ram_wdata = load_data;
        ram_we    = beat;
        if (in_run) begin
            ram_addr  = addr_toRAM;
            ram_wdata = data_toRAM;
            ram_we    = wrEn && !prot_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            ptr        <= '0;
            cpu_rst    <= 1'b1;
            load_ready <= 1'b1;
            loaded     <= 1'b0;
        end else if (beat) begin
            // Last beat, or the top word: finish here rather than wrap onto address 0.
            if (load_last || ptr == '1) begin
                state      <= RUN;
                cpu_rst    <= 1'b0;
                load_ready <= 1'b0;
                loaded     <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

`ifdef CPU_RAM2021_WRPROT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          prot_viol <= 1'b0;
        else if (in_run && wrEn && prot_hit) prot_viol <= 1'b1;
    end
`else
    assign prot_viol = 1'b0;
`endif

    cpu_ram2021_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .clr  (!in_run),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(data_fromRAM)
    );
endmodule

// File: tb/tb_cpu_ram2021.sv
// Directed bench for cpu_ram2021: loader sequences, RUN read/write tables, reset and protection.
module tb_cpu_ram2021;
    localparam int AW = 13;
`ifdef CPU_RAM2021_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic          chk;
        logic [15:0]   exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrEn = 1'b0;
    logic [AW-1:0] addr_toRAM = '0;
    logic [15:0]   data_toRAM = '0;
    logic [15:0]   data_fromRAM;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          cpu_rst;
    logic          loaded;
    logic          prot_viol;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tab_a[6];
    vec_t tab_b[3];
    vec_t tab_c[3];
    vec_t tab_d[6];

    cpu_ram2021 #(.ADDR_W(AW), .PROT_TOP(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .addr_toRAM  (addr_toRAM),
        .data_toRAM  (data_toRAM),
        .data_fromRAM(data_fromRAM),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .cpu_rst     (cpu_rst),
        .loaded      (loaded),
        .prot_viol   (prot_viol)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input int i);
        return 16'(i) ^ 16'h5A00;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one cycle of CPU traffic and checks read data after the edge.
    task automatic apply(input vec_t v, input string name);
        wrEn       = v.wr;
        addr_toRAM = v.addr;
        data_toRAM = v.wdata;
        @(posedge clk);
        @(negedge clk);
        wrEn = 1'b0;
        if (v.chk) chk16(name, data_fromRAM, v.exp);
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tab_a[0] = '{1'b0, 13'd1,     16'h0000, 1'b1, 16'h2222};
        tab_a[1] = '{1'b0, 13'd0,     16'h0000, 1'b1, 16'h1111};
        tab_a[2] = '{1'b0, 13'd2,     16'h0000, 1'b1, 16'h3333};
        tab_a[3] = '{1'b1, 13'h0100,  16'h1234, 1'b0, 16'h0000};
        tab_a[4] = '{1'b1, 13'h0100,  16'hBEEF, 1'b1, 16'h1234};
        tab_a[5] = '{1'b0, 13'h0100,  16'h0000, 1'b1, 16'hBEEF};

        tab_b[0] = '{1'b0, 13'd0,     16'h0000, 1'b1, 16'hC0DE};
        tab_b[1] = '{1'b0, 13'd1,     16'h0000, 1'b1, 16'h2222};
        tab_b[2] = '{1'b0, 13'h0100,  16'h0000, 1'b1, 16'hBEEF};

        tab_c[0] = '{1'b0, 13'd0,     16'h0000, 1'b1, 16'hA0A0};
        tab_c[1] = '{1'b0, 13'd1,     16'h0000, 1'b1, 16'hB1B1};
        tab_c[2] = '{1'b0, 13'd2,     16'h0000, 1'b1, 16'h3333};

        tab_d[0] = '{1'b0, 13'd0,     16'h0000, 1'b1, word(0)};
        tab_d[1] = '{1'b0, 13'h1FFF,  16'h0000, 1'b1, word(8191)};
        tab_d[2] = '{1'b1, 13'd5,     16'h00FF, 1'b1, word(5)};
        tab_d[3] = '{1'b0, 13'd5,     16'h0000, 1'b1, PROT ? word(5) : 16'h00FF};
        tab_d[4] = '{1'b1, 13'd16,    16'h7777, 1'b1, word(16)};
        tab_d[5] = '{1'b0, 13'd16,    16'h0000, 1'b1, 16'h7777};

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk16("rst_data", data_fromRAM, 16'h0000);
        chk1("rst_cpu_rst", cpu_rst, 1'b1);
        chk1("rst_load_ready", load_ready, 1'b1);
        chk1("rst_loaded", loaded, 1'b0);
        chk1("rst_prot_viol", prot_viol, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Three-beat load; a CPU write during LOAD must be ignored
        beat(16'h1111, 1'b0);
        chk16("load_data_held0", data_fromRAM, 16'h0000);
        chk1("load_cpu_rst", cpu_rst, 1'b1);
        beat(16'h2222, 1'b0);
        wrEn = 1'b1; addr_toRAM = 13'd1; data_toRAM = 16'h9999;
        beat(16'h3333, 1'b1);
        wrEn = 1'b0;
        chk1("run_loaded", loaded, 1'b1);
        chk1("run_cpu_rst", cpu_rst, 1'b0);
        chk1("run_load_ready", load_ready, 1'b0);
        chk16("run_first_data", data_fromRAM, 16'h0000);
        foreach (tab_a[i]) apply(tab_a[i], $sformatf("tabA%0d", i));

        // Reset pulse in RUN: outputs change immediately, memory survives a 1-beat reload
        #2 rst = 1'b0;
        #1;
        chk1("rstrun_cpu_rst", cpu_rst, 1'b1);
        chk1("rstrun_load_ready", load_ready, 1'b1);
        chk16("rstrun_data", data_fromRAM, 16'h0000);
        chk1("rstrun_loaded", loaded, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        beat(16'hC0DE, 1'b1);
        chk1("reload_loaded", loaded, 1'b1);
        foreach (tab_b[i]) apply(tab_b[i], $sformatf("tabB%0d", i));

        // Reset mid-LOAD restarts at 0; gapped valid with last on beat 2 writes two words
        do_reset();
        beat(16'hEEEE, 1'b0);
        chk1("midload_loaded", loaded, 1'b0);
        do_reset();
        beat(16'hA0A0, 1'b0);
        load_data = 16'hDEAD;
        load_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_last = 1'b0;
        chk1("gap_load_ready", load_ready, 1'b1);
        beat(16'hB1B1, 1'b1);
        chk1("gap_loaded", loaded, 1'b1);
        foreach (tab_c[i]) apply(tab_c[i], $sformatf("tabC%0d", i));

        // Full-depth load without last: ends at the top word, never wraps
        do_reset();
        for (int i = 0; i < 8192; i++) begin
            if (i == 8191) chk1("full_not_done", loaded, 1'b0);
            beat(word(i), 1'b0);
        end
        chk1("full_loaded", loaded, 1'b1);
        chk1("full_load_ready", load_ready, 1'b0);
        beat(16'hFFFF, 1'b0);
        foreach (tab_d[i]) apply(tab_d[i], $sformatf("tabD%0d", i));
        chk1("prot_viol_sticky", prot_viol, PROT);
        apply('{1'b0, 13'd0, 16'h0000, 1'b0, 16'h0000}, "idle");
        chk1("prot_viol_hold", prot_viol, PROT);
        #2 rst = 1'b0;
        #1;
        chk1("prot_viol_rst", prot_viol, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
